// File: rtl/fb_pkg.sv
// Shared constants, colour helpers and pipeline tag layout for the framebuffer pixel fetch path.
package fb_pkg;

    localparam int unsigned SRC_W_DEF    = 640;
    localparam int unsigned SRC_H_DEF    = 240;
    localparam int unsigned PIX_PER_BYTE = 4;
    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 10;
    localparam int unsigned SEL_W        = 2;

    localparam logic [15:0] FG_RGB_DEF     = 16'hFFFF;
    localparam logic [15:0] BG_RGB_DEF     = 16'h0000;
    localparam logic [15:0] BORDER_RGB_DEF = 16'h001F;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Per-pixel side information that travels alongside the BRAM read.
    typedef struct packed {
        logic             de;
        logic             hs;
        logic             vs;
        logic             in_win;
        logic [SEL_W-1:0] sel;
    } fetch_tag_t;

    function automatic rgb565_t rgb565_split(input logic [15:0] rgb);
        rgb565_t c;
        c.r = rgb[15:11];
        c.g = rgb[10:5];
        c.b = rgb[4:0];
        return c;
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Fixed-depth shift register with synchronous reset; keeps side-band data aligned with BRAM read data.
module fb_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_pixel_fetch.sv
// Raster-to-framebuffer fetch: counts DE/VSYNC, issues BRAM byte reads and emits aligned RGB565 pixels.
// Optional LINE_DOUBLE_EN macro shows each source line twice (y_src = y >> 1).
module fb_pixel_fetch
    import fb_pkg::*;
#(
    parameter int unsigned SRC_W        = SRC_W_DEF,
    parameter int unsigned SRC_H        = SRC_H_DEF,
    parameter int unsigned PIX_PER_BYTE = fb_pkg::PIX_PER_BYTE,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned READ_LAT     = 2,
    parameter logic [15:0] FG_RGB       = FG_RGB_DEF,
    parameter logic [15:0] BG_RGB       = BG_RGB_DEF,
    parameter logic [15:0] BORDER_RGB   = BORDER_RGB_DEF
) (
    input  logic              PixelClk,
    input  logic              RST,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_ce,
    input  logic [7:0]        bram_dout,
    output logic              LCD_DE,
    output logic              LCD_HSYNC,
    output logic              LCD_VSYNC,
    output logic [4:0]        LCD_R,
    output logic [5:0]        LCD_G,
    output logic [4:0]        LCD_B
);

    localparam int unsigned IDX_W   = ADDR_W + 2;
    localparam int unsigned SHIFT_W = $clog2(PIX_PER_BYTE);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             de_prev_q;
    logic             vs_prev_q;
    logic [Y_W-1:0]   y_src;
    logic             in_win;
    logic [IDX_W-1:0] pixel_index;
    fetch_tag_t       tag_in;
    fetch_tag_t       tag_dly;
    logic             pix_bit;
    rgb565_t          rgb_d, rgb_q;
    logic             lcd_de_q, lcd_hs_q, lcd_vs_q;

    // Raster position: vsync rise beats a DE fall landing on the same cycle.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vsync_in && !vs_prev_q) begin
            x_d = '0;
            y_d = '0;
        end else if (!de_in && de_prev_q) begin
            x_d = '0;
            if (y_q != Y_MAX) begin
                y_d = y_q + Y_W'(1);
            end
        end else if (de_in && (x_q != X_MAX)) begin
            x_d = x_q + X_W'(1);
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            x_q       <= '0;
            y_q       <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            de_prev_q <= de_in;
            vs_prev_q <= vsync_in;
        end
    end

`ifdef LINE_DOUBLE_EN
    assign y_src = y_q >> 1;
`else
    assign y_src = y_q;
`endif

    assign in_win      = (32'(x_q) < SRC_W) && (32'(y_src) < SRC_H);
    assign pixel_index = IDX_W'(y_src) * IDX_W'(SRC_W) + IDX_W'(x_q);

    // Address is combinational from the counters so the read lands READ_LAT cycles later.
    assign bram_addr = RST ? '0 : ADDR_W'(pixel_index >> SHIFT_W);
    assign bram_ce   = !RST && de_in && in_win;

    always_comb begin
        tag_in        = '0;
        tag_in.de     = de_in;
        tag_in.hs     = hsync_in;
        tag_in.vs     = vsync_in;
        tag_in.in_win = in_win;
        tag_in.sel    = pixel_index[SEL_W-1:0];
    end

    fb_delay_line #(
        .WIDTH ($bits(fetch_tag_t)),
        .DEPTH (READ_LAT)
    ) u_align (
        .clk_i (PixelClk),
        .rst_i (RST),
        .d_i   (tag_in),
        .q_o   (tag_dly)
    );

    assign pix_bit = bram_dout[3'(tag_dly.sel)];

    // Colour select; BRAM data only matters for active, in-window pixels.
    always_comb begin
        rgb_d = '0;
        if (!tag_dly.de) begin
            rgb_d = '0;
        end else if (!tag_dly.in_win) begin
            rgb_d = rgb565_split(BORDER_RGB);
        end else begin
            rgb_d = rgb565_split(pix_bit ? FG_RGB : BG_RGB);
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            rgb_q    <= '0;
            lcd_de_q <= 1'b0;
            lcd_hs_q <= 1'b0;
            lcd_vs_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            lcd_de_q <= tag_dly.de;
            lcd_hs_q <= tag_dly.hs;
            lcd_vs_q <= tag_dly.vs;
        end
    end

    assign LCD_DE    = lcd_de_q;
    assign LCD_HSYNC = lcd_hs_q;
    assign LCD_VSYNC = lcd_vs_q;
    assign LCD_R     = rgb_q.r;
    assign LCD_G     = rgb_q.g;
    assign LCD_B     = rgb_q.b;

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Randomised bench for fb_pixel_fetch with a raster-level reference model and a latency-2 BRAM model.
module tb_fb_pixel_fetch;

    localparam int LAT = 3;

    logic        PixelClk;
    logic        RST;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [18:0] bram_addr;
    logic        bram_ce;
    logic [7:0]  bram_dout;
    logic        LCD_DE;
    logic        LCD_HSYNC;
    logic        LCD_VSYNC;
    logic [4:0]  LCD_R;
    logic [5:0]  LCD_G;
    logic [4:0]  LCD_B;

    fb_pixel_fetch dut (
        .PixelClk  (PixelClk),
        .RST       (RST),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .bram_addr (bram_addr),
        .bram_ce   (bram_ce),
        .bram_dout (bram_dout),
        .LCD_DE    (LCD_DE),
        .LCD_HSYNC (LCD_HSYNC),
        .LCD_VSYNC (LCD_VSYNC),
        .LCD_R     (LCD_R),
        .LCD_G     (LCD_G),
        .LCD_B     (LCD_B)
    );

    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    int          n_tests;
    int          n_fail;
    logic [31:0] seed;
    logic [31:0] last_addr;

    // Framebuffer contents: address 0 holds 8'h05, the rest is seeded noise.
    function automatic logic [7:0] mem_byte(input int a);
        if (a == 0) return 8'h05;
        return 8'(a * 29 + (a >> 5) + int'(seed));
    endfunction

    // Synchronous BRAM, two cycles from address to data, holds address when disabled.
    logic [18:0] rd_a1 = '0;
    logic [18:0] rd_a2 = '0;
    always @(posedge PixelClk) begin
        if (bram_ce) rd_a1 <= bram_addr;
        rd_a2 <= rd_a1;
    end
    assign bram_dout = mem_byte(int'(rd_a2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference raster state, in source-frame coordinates.
    int mx, my;
    bit prev_de, prev_vs;
    logic [18:0] exp_q [$];

    function automatic int ysrc_of(input int y);
`ifdef LINE_DOUBLE_EN
        return y / 2;
`else
        return y;
`endif
    endfunction

    function automatic logic [18:0] out_word(input bit de, input bit hs, input bit vs,
                                             input bit win, input int idx);
        logic [15:0] rgb;
        logic [7:0]  byt;
        if (!de)       rgb = 16'h0000;
        else if (!win) rgb = 16'h001F;
        else begin
            byt = mem_byte(idx / 4);
            rgb = byt[idx % 4] ? 16'hFFFF : 16'h0000;
        end
        return {de, hs, vs, rgb};
    endfunction

    task automatic step(input bit de, input bit hs, input bit vs, input bit rst);
        int          ys;
        int          idx;
        bit          win;
        logic [18:0] e;
        RST      = rst;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        @(negedge PixelClk);
        ys  = ysrc_of(my);
        win = (mx < 640) && (ys < 240);
        idx = ys * 640 + mx;
        chk("addr", 32'(bram_addr), rst ? 32'd0 : 32'(idx / 4));
        chk("ce", 32'(bram_ce), 32'(!rst && de && win));
        last_addr = 32'(bram_addr);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("lcd", 32'({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B}), 32'(e));
        end
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < LAT; i++) exp_q.push_back('0);
        end else begin
            exp_q.push_back(out_word(de, hs, vs, win, idx));
        end
        @(posedge PixelClk);
        if (rst) begin
            mx = 0; my = 0; prev_de = 0; prev_vs = 0;
        end else begin
            if (vs && !prev_vs) begin
                mx = 0; my = 0;
            end else if (!de && prev_de) begin
                mx = 0;
                my = (my < 1023) ? my + 1 : 1023;
            end else if (de) begin
                mx = (mx < 1023) ? mx + 1 : 1023;
            end
            prev_de = de;
            prev_vs = vs;
        end
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic line(input int n_de, input int n_blank);
        for (int i = 0; i < n_de; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n_blank; i++) step(1'b0, i == 1, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        seed    = $urandom;
        mx = 0; my = 0; prev_de = 0; prev_vs = 0;

        // reset with random inputs
        for (int i = 0; i < 3; i++)
            step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b1);
        blank(2);

        // full-width lines, window edge and x saturation
        vs_pulse(2);
        blank(3);
        line(640, 12);
        step(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef LINE_DOUBLE_EN
        chk("line1_start", last_addr, 32'd0);
`else
        chk("line1_start", last_addr, 32'd160);
`endif
        line(639, 12);
        line(800, 12);
        line(1100, 6);

        // 480 short lines covering the bottom frame edge
        vs_pulse(3);
        blank(4);
        for (int l = 0; l < 480; l++) line($urandom_range(1, 10), $urandom_range(2, 4));

        // vsync rise coincident with DE fall
        vs_pulse(2);
        blank(2);
        for (int l = 0; l < 5; l++) line(16, 3);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        blank(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("vs_wins_addr", last_addr, 32'd0);
        line(15, 3);
        line(20, 3);

        // reset in the middle of a line, then resync on vsync
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        line(12, 4);
        vs_pulse(2);
        blank(2);
        line(24, 4);
        line(24, 4);

        // random raster noise with occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 64) == 0,
                 ($urandom % 300) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
